skf_exhaustive_checker: RTL

- Sequential harness that sits on both sides of a synthesized Skolem-function block: drives its universally-quantified inputs (upstream) and consumes its existentially-quantified outputs (downstream).
- Sweeps all 2^N_IN input assignments and checks each output vector against the xor specification: XOR of all N_IN+N_OUT bits == PARITY_TARGET.
- Reports pass/fail, failure count and first failing assignment; used to validate generated Skolem netlists in simulation and on FPGA.

---
 rtl/skf_exhaustive_checker.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/skf_exhaustive_checker.sv
// skf_exhaustive_checker
//
// Exhaustive checker for a synthesized Skolem-function block. It drives every
// x assignment from 0 up to all-ones, waits SETTLE_CYCLES, samples y and checks
// that XOR of {x, y} equals PARITY_TARGET.
//
// Ports:
//   clk              clock
//   rst_n            asynchronous active-low reset
//   start            one-cycle pulse, begins a sweep from IDLE or DONE
//   abort            synchronous abort back to IDLE (results held)
//   x_out[N_IN]      assignment driven to the Skolem block
//   y_in[N_OUT]      Skolem block outputs, sampled only in CHECK
//   busy             sweep in progress
//   done             sweep complete, held until next start
//   pass             done with zero failures
//   fail_count[N_IN+1] failing assignments, saturates at 2^N_IN
//   first_fail_valid at least one failure recorded
//   first_fail_x[N_IN] x of the first failure
//
// Optional build macro SKF_STOP_ON_FAIL_EN: the first failing CHECK ends the
// sweep in DONE, with x_out holding the failing assignment.
//
// state  | meaning
// IDLE   | waiting for start
// SETTLE | x_out held while the Skolem block output settles
// CHECK  | y_in sampled and parity checked, then step to next x
// DONE   | sweep finished, results held until next start

module skf_exhaustive_checker #(
    parameter int N_IN          = 8,
    parameter int N_OUT         = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter int PARITY_TARGET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   x_out,
    input  logic [N_OUT-1:0]  y_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     fail_count,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_x
);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    // x is counted one bit wider so the terminal compare never aliases a wrap.
    localparam logic [N_IN:0] X_LAST   = {1'b0, {N_IN{1'b1}}};
    localparam logic [N_IN:0] FAIL_MAX = {1'b1, {N_IN{1'b0}}};
    localparam logic [N_IN:0] ONE      = {{N_IN{1'b0}}, 1'b1};
    localparam logic [3:0]    SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam state_t        STEP_STATE  = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
    localparam logic          TARGET      = 1'(PARITY_TARGET);

    state_t          state, state_nxt;
    logic [N_IN:0]   x_cnt, x_cnt_nxt;
    logic [3:0]      settle_cnt, settle_cnt_nxt;
    logic [N_IN:0]   fail_cnt, fail_cnt_nxt;
    logic            ff_valid, ff_valid_nxt;
    logic [N_IN-1:0] ff_x, ff_x_nxt;
    logic            mismatch;
    logic            end_sweep;

    // Gating with the state first keeps an X on y_in outside CHECK from leaking.
    assign mismatch = (state == CHECK) && ((^{x_cnt[N_IN-1:0], y_in}) != TARGET);

`ifdef SKF_STOP_ON_FAIL_EN
    assign end_sweep = mismatch || (x_cnt == X_LAST);
`else
    assign end_sweep = (x_cnt == X_LAST);
`endif

    always_comb begin
        state_nxt      = state;
        x_cnt_nxt      = x_cnt;
        settle_cnt_nxt = settle_cnt;
        fail_cnt_nxt   = fail_cnt;
        ff_valid_nxt   = ff_valid;
        ff_x_nxt       = ff_x;

        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt      = STEP_STATE;
                    x_cnt_nxt      = '0;
                    settle_cnt_nxt = SETTLE_LOAD;
                    fail_cnt_nxt   = '0;
                    ff_valid_nxt   = 1'b0;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    state_nxt = CHECK;
                end else begin
                    settle_cnt_nxt = settle_cnt - 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (fail_cnt != FAIL_MAX) begin
                        fail_cnt_nxt = fail_cnt + ONE;
                    end
                    if (!ff_valid) begin
                        ff_valid_nxt = 1'b1;
                        ff_x_nxt     = x_cnt[N_IN-1:0];
                    end
                end
                if (end_sweep) begin
                    state_nxt = DONE;
                end else begin
                    x_cnt_nxt      = x_cnt + ONE;
                    settle_cnt_nxt = SETTLE_LOAD;
                    state_nxt      = STEP_STATE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Abort wins over start and over any CHECK update; results stay for debug.
        if (abort) begin
            state_nxt      = IDLE;
            x_cnt_nxt      = '0;
            settle_cnt_nxt = 4'd0;
            fail_cnt_nxt   = fail_cnt;
            ff_valid_nxt   = ff_valid;
            ff_x_nxt       = ff_x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            x_cnt      <= '0;
            settle_cnt <= 4'd0;
            fail_cnt   <= '0;
            ff_valid   <= 1'b0;
            ff_x       <= '0;
        end else begin
            state      <= state_nxt;
            x_cnt      <= x_cnt_nxt;
            settle_cnt <= settle_cnt_nxt;
            fail_cnt   <= fail_cnt_nxt;
            ff_valid   <= ff_valid_nxt;
            ff_x       <= ff_x_nxt;
        end
    end

    assign x_out            = x_cnt[N_IN-1:0];
    assign busy             = (state == SETTLE) || (state == CHECK);
    assign done             = (state == DONE);
    assign pass             = (state == DONE) && (fail_cnt == '0);
    assign fail_count       = fail_cnt;
    assign first_fail_valid = ff_valid;
    assign first_fail_x     = ff_x;

endmodule
